// File: rtl/i2c_line_count_logger.sv
// Sends each accepted frame_lines sample to the diagnostic logger as a single I2C master write.
// Define I2C_SEQ_BYTE_EN to append a per-transaction sequence byte after the line count.
module i2c_line_count_logger #(
   parameter int unsigned CLK_DIV    = 4,
   parameter logic [6:0]  SLAVE_ADDR = 7'h08
) (
   input  logic       cam_pclk,
   input  logic       cam_reset,
   input  logic       new_frame,
   input  logic [9:0] frame_lines,
   output logic       busy,
   output logic       scl_oe,
   output logic       sda_oe,
   input  logic       sda_in,
   output logic       ack_err,
   output logic [7:0] drop_cnt
);

   localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
`ifdef I2C_SEQ_BYTE_EN
   localparam logic [1:0] LastByte = 2'd3;
`else
   localparam logic [1:0] LastByte = 2'd2;
`endif

   typedef enum logic [2:0] {StIdle, StStart, StData, StAck, StStop} state_e;

   state_e          state_q, state_d;
   logic [DivW-1:0] div_q, div_d;
   logic [1:0]      qtr_q, qtr_d;
   logic [2:0]      bit_q, bit_d;
   logic [1:0]      byte_q, byte_d;
   logic [7:0]      shreg_q, shreg_d;
   logic [9:0]      lines_q, lines_d;
   logic            nack_q, nack_d;
   logic [7:0]      drop_q, drop_d;
   logic            busy_q, scl_q, sda_q, ack_err_q;
   logic            scl_d, sda_d, ack_err_d;
   logic [7:0]      next_byte;
   logic            tick, sample, bit_end;
`ifdef I2C_SEQ_BYTE_EN
   logic [7:0]      seq_q, seq_d;
`endif

   assign tick    = (div_q == DivW'(CLK_DIV - 1));
   assign sample  = tick && (qtr_q == 2'd2);
   assign bit_end = tick && (qtr_q == 2'd3);

   // Byte loaded after the ACK slot of byte_q.
   always_comb begin
      next_byte = lines_q[7:0];
      case (byte_q)
         2'd0:    next_byte = {6'b0, lines_q[9:8]};
         2'd1:    next_byte = lines_q[7:0];
`ifdef I2C_SEQ_BYTE_EN
         2'd2:    next_byte = seq_q;
`endif
         default: next_byte = lines_q[7:0];
      endcase
   end

   always_comb begin
      state_d   = state_q;
      div_d     = div_q;
      qtr_d     = qtr_q;
      bit_d     = bit_q;
      byte_d    = byte_q;
      shreg_d   = shreg_q;
      lines_d   = lines_q;
      nack_d    = nack_q;
      drop_d    = drop_q;
      ack_err_d = 1'b0;
`ifdef I2C_SEQ_BYTE_EN
      seq_d     = seq_q;
`endif
      if (state_q == StIdle) begin
         if (new_frame) begin
            state_d = StStart;
            lines_d = frame_lines;
            nack_d  = 1'b0;
            div_d   = '0;
            qtr_d   = 2'd0;
         end
      end else begin
         if (new_frame && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
         div_d = tick ? '0 : div_q + DivW'(1);
         if (tick) qtr_d = qtr_q + 2'd1;
         if (state_q == StAck && sample && sda_in) begin
            nack_d    = 1'b1;
            ack_err_d = 1'b1;
         end
         if (bit_end) begin
            case (state_q)
               StStart: begin
                  state_d = StData;
                  bit_d   = 3'd0;
                  byte_d  = 2'd0;
                  shreg_d = {SLAVE_ADDR, 1'b0};
               end
               StData: begin
                  if (bit_q == 3'd7) begin
                     state_d = StAck;
                  end else begin
                     bit_d   = bit_q + 3'd1;
                     shreg_d = {shreg_q[6:0], 1'b0};
                  end
               end
               StAck: begin
                  if (nack_q || byte_q == LastByte) begin
                     state_d = StStop;
                  end else begin
                     state_d = StData;
                     bit_d   = 3'd0;
                     byte_d  = byte_q + 2'd1;
                     shreg_d = next_byte;
                  end
               end
               StStop: begin
                  state_d = StIdle;
`ifdef I2C_SEQ_BYTE_EN
                  if (!nack_q) seq_d = seq_q + 8'd1;
`endif
               end
               default: state_d = StIdle;
            endcase
         end
      end
   end

   // Pad drive is decoded from next-state so the registered outputs line up with the phase.
   always_comb begin
      scl_d = 1'b0;
      sda_d = 1'b0;
      case (state_d)
         StStart: begin
            sda_d = qtr_d[1];
            scl_d = (qtr_d == 2'd3);
         end
         StData: begin
            scl_d = ~qtr_d[1];
            sda_d = ~shreg_d[7];
         end
         StAck:   scl_d = ~qtr_d[1];
         StStop: begin
            scl_d = (qtr_d == 2'd0);
            sda_d = ~qtr_d[1];
         end
         default: ;
      endcase
   end

   always_ff @(posedge cam_pclk) begin
      if (cam_reset) begin
         state_q   <= StIdle;
         div_q     <= '0;
         qtr_q     <= 2'd0;
         bit_q     <= 3'd0;
         byte_q    <= 2'd0;
         shreg_q   <= 8'd0;
         lines_q   <= 10'd0;
         nack_q    <= 1'b0;
         drop_q    <= 8'd0;
         busy_q    <= 1'b0;
         scl_q     <= 1'b0;
         sda_q     <= 1'b0;
         ack_err_q <= 1'b0;
`ifdef I2C_SEQ_BYTE_EN
         seq_q     <= 8'd0;
`endif
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         qtr_q     <= qtr_d;
         bit_q     <= bit_d;
         byte_q    <= byte_d;
         shreg_q   <= shreg_d;
         lines_q   <= lines_d;
         nack_q    <= nack_d;
         drop_q    <= drop_d;
         busy_q    <= (state_d != StIdle);
         scl_q     <= scl_d;
         sda_q     <= sda_d;
         ack_err_q <= ack_err_d;
`ifdef I2C_SEQ_BYTE_EN
         seq_q     <= seq_d;
`endif
      end
   end

   assign busy     = busy_q;
   assign scl_oe   = scl_q;
   assign sda_oe   = sda_q;
   assign ack_err  = ack_err_q;
   assign drop_cnt = drop_q;

endmodule

// File: tb/tb_i2c_line_count_logger.sv
// Bench for i2c_line_count_logger: I2C slave/bus monitor, vector table and randomized
// transactions checked against a byte-level reference model.
module tb_i2c_line_count_logger;

   localparam int unsigned CLK_DIV = 2;
   localparam int BIT_CYC = 4 * CLK_DIV;
`ifdef I2C_SEQ_BYTE_EN
   localparam int NBYTES = 4;
`else
   localparam int NBYTES = 3;
`endif
   localparam int FULL_CYC = (2 + 9 * NBYTES) * BIT_CYC;

   typedef struct {
      int          n;
      logic [31:0] bytes;
   } frame_t;

   typedef struct {
      logic [9:0] lines;
      int         nb;
      int         exp_cyc;
      int         exp_errs;
   } vec_t;

   logic       cam_pclk = 1'b0;
   logic       cam_reset = 1'b1;
   logic       new_frame = 1'b0;
   logic [9:0] frame_lines = 10'd0;
   logic       busy, scl_oe, sda_oe, sda_in, ack_err;
   logic [7:0] drop_cnt;

   i2c_line_count_logger #(
      .CLK_DIV    (CLK_DIV),
      .SLAVE_ADDR (7'h08)
   ) dut (
      .cam_pclk    (cam_pclk),
      .cam_reset   (cam_reset),
      .new_frame   (new_frame),
      .frame_lines (frame_lines),
      .busy        (busy),
      .scl_oe      (scl_oe),
      .sda_oe      (sda_oe),
      .sda_in      (sda_in),
      .ack_err     (ack_err),
      .drop_cnt    (drop_cnt)
   );

   always #5 cam_pclk = ~cam_pclk;

   int checks = 0;
   int errors = 0;
   int nack_byte = -1;
   logic slave_pull = 1'b0;

   assign sda_in = ~(sda_oe | slave_pull);

   function automatic void check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endfunction

   // Slave + bus decoder working only from the wire levels.
   frame_t     got_q[$];
   frame_t     cur = '{0, 32'd0};
   logic       p_scl = 1'b1, p_sda = 1'b1, in_frame = 1'b0;
   logic       scl_now, sda_now;
   logic [7:0] sh = 8'd0;
   int         nbits = 0;

   always @(negedge cam_pclk) begin
      if (cam_reset) begin
         in_frame   = 1'b0;
         nbits      = 0;
         slave_pull = 1'b0;
         p_scl      = 1'b1;
         p_sda      = 1'b1;
      end else begin
         scl_now = ~scl_oe;
         sda_now = sda_in;
         if (p_scl && scl_now && p_sda && !sda_now) begin
            in_frame  = 1'b1;
            nbits     = 0;
            cur.n     = 0;
            cur.bytes = 32'd0;
         end else if (p_scl && scl_now && !p_sda && sda_now) begin
            if (in_frame) got_q.push_back(cur);
            in_frame = 1'b0;
         end else if (in_frame && !p_scl && scl_now) begin
            if (nbits < 8) sh = {sh[6:0], sda_now};
            nbits++;
            if (nbits == 8 && cur.n < 4) begin
               cur.bytes[8*cur.n +: 8] = sh;
               cur.n++;
            end
         end else if (in_frame && p_scl && !scl_now) begin
            if (nbits == 8) begin
               slave_pull = (nack_byte != cur.n - 1);
            end else if (nbits == 9) begin
               slave_pull = 1'b0;
               nbits      = 0;
            end
         end
         p_scl = scl_now;
         p_sda = sda_now;
      end
   end

   // Reference: the bytes a transfer should put on the bus, from the value alone.
   function automatic frame_t model_frame(input logic [9:0] lines, input int nb,
                                          input logic [7:0] seq);
      logic [7:0] b [4];
      frame_t     f;
      b[0] = 8'(8'h08 * 2);
      b[1] = 8'(int'(lines) / 256);
      b[2] = 8'(int'(lines) % 256);
      b[3] = seq;
      f.n = (nb < 0) ? NBYTES : nb + 1;
      f.bytes = 32'd0;
      for (int i = 0; i < f.n; i++) f.bytes[8*i +: 8] = b[i];
      return f;
   endfunction

   function automatic int model_cycles(input int nb);
      int n = (nb < 0) ? NBYTES : nb + 1;
      return (2 + 9 * n) * BIT_CYC;
   endfunction

   task automatic check_frame(input string name, input frame_t e);
      frame_t g;
      check({name, "_frames"}, got_q.size(), 1);
      if (got_q.size() > 0) begin
         g = got_q.pop_front();
         check({name, "_nbytes"}, g.n, e.n);
         check({name, "_bytes"}, g.bytes, e.bytes);
      end
      got_q.delete();
   endtask

   // Called at posedge+1 with busy low; returns at posedge+1 of the first cycle busy is low.
   task automatic run_txn(input logic [9:0] lines, input int nb, input int drop_at,
                          input int rst_at, output int cyc, output int errs);
      nack_byte   = nb;
      frame_lines = lines;
      new_frame   = 1'b1;
      @(posedge cam_pclk); #1;
      new_frame = 1'b0;
      cyc  = 0;
      errs = 0;
      while (busy && cyc < 4000) begin
         cyc++;
         if (ack_err) errs++;
         new_frame = (cyc == drop_at);
         if (cyc == drop_at) frame_lines = ~lines;
         if (cyc == rst_at) begin
            cam_reset = 1'b1;
            @(posedge cam_pclk); #1;
            cam_reset = 1'b0;
            check("rst_scl_oe", int'(scl_oe), 0);
            check("rst_sda_oe", int'(sda_oe), 0);
            check("rst_busy", int'(busy), 0);
            check("rst_drop_cnt", int'(drop_cnt), 0);
            break;
         end
         @(posedge cam_pclk); #1;
      end
      new_frame = 1'b0;
   endtask

   initial begin
      vec_t       vecs [7];
      int         cyc, errs, nb, gap;
      logic [9:0] lines;
      logic [7:0] seq;
      frame_t     e;

      vecs[0] = '{10'd263,  -1, FULL_CYC, 0};
      vecs[1] = '{10'd0,    -1, FULL_CYC, 0};
      vecs[2] = '{10'd1023, -1, FULL_CYC, 0};
      vecs[3] = '{10'd512,   0, 88,       1};
      vecs[4] = '{10'd255,  -1, FULL_CYC, 0};
      vecs[5] = '{10'd341,   1, 160,      1};
      vecs[6] = '{10'd682,   2, 232,      1};
      seq = 8'd0;

      repeat (3) @(posedge cam_pclk);
      #1;
      cam_reset = 1'b0;
      @(posedge cam_pclk); #1;
      check("reset_busy", int'(busy), 0);
      check("reset_scl_oe", int'(scl_oe), 0);
      check("reset_sda_oe", int'(sda_oe), 0);
      check("reset_ack_err", int'(ack_err), 0);
      check("reset_drop_cnt", int'(drop_cnt), 0);

      // 263 lines with a request dropped 5 cycles in.
      run_txn(10'd263, -1, 5, -1, cyc, errs);
      check("drop_busy_cycles", cyc, FULL_CYC);
      check("drop_ack_err", errs, 0);
      check("drop_cnt_one", int'(drop_cnt), 1);
      check_frame("drop_263", '{NBYTES, 32'h0007_0110});
      seq = seq + 8'd1;

      // Table entries run back to back.
      for (int i = 0; i < 7; i++) begin
         e = model_frame(vecs[i].lines, vecs[i].nb, seq);
         run_txn(vecs[i].lines, vecs[i].nb, -1, -1, cyc, errs);
         check($sformatf("vec%0d_cycles", i), cyc, vecs[i].exp_cyc);
         check($sformatf("vec%0d_ack_err", i), errs, vecs[i].exp_errs);
         check_frame($sformatf("vec%0d", i), e);
         if (vecs[i].nb < 0) seq = seq + 8'd1;
      end

      // Reset in the middle of the high line-count byte.
      run_txn(10'd700, -1, -1, BIT_CYC * 13 + 3, cyc, errs);
      repeat (4) @(posedge cam_pclk);
      #1;
      check("rst_no_frame", got_q.size(), 0);
      seq = 8'd0;
      e = model_frame(10'd700, -1, seq);
      run_txn(10'd700, -1, -1, -1, cyc, errs);
      check("post_rst_cycles", cyc, FULL_CYC);
      check_frame("post_rst", e);
      seq = seq + 8'd1;

      for (int i = 0; i < 24; i++) begin
         lines = 10'($urandom_range(0, 1023));
         nb    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NBYTES - 1)) : -1;
         gap   = int'($urandom_range(0, 3));
         repeat (gap) @(posedge cam_pclk);
         #1;
         e = model_frame(lines, nb, seq);
         run_txn(lines, nb, -1, -1, cyc, errs);
         check($sformatf("rnd%0d_cycles", i), cyc, model_cycles(nb));
         check($sformatf("rnd%0d_ack_err", i), errs, (nb < 0) ? 0 : 1);
         check_frame($sformatf("rnd%0d", i), e);
         if (nb < 0) seq = seq + 8'd1;
      end
      check("final_drop_cnt", int'(drop_cnt), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
